trap_csr_unit: RTL and testbench
================================

Name: trap_csr_unit

Overview:
- Machine-mode trap and CSR block for the pipelined core.
- Sits downstream of the control unit and consumes the EX-stage IntCause and MRet control signals, plus CSR access requests.
- Holds mstatus, mie, mip, mtvec, mepc and mcause.
- Synchronises the external interrupt, arbitrates trap, interrupt and mret events, and issues a one-cycle registered flush-and-redirect to the fetch stage.

Parameters:
XLEN, 32, data/address width
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] must be 0)

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
ex_valid  input  1  EX stage holds a real instruction (not a bubble)
ex_pc  input  XLEN  PC of EX-stage instruction
int_cause  input  2  IntCause from control: 00 none, 01 illegal, 10 ecall, 11 ebreak
mret  input  1  MRet from control
ext_irq  input  1  asynchronous external interrupt level
csr_we  input  1  CSR instruction in EX requests access
csr_op  input  2  01 write, 10 set bits, 11 clear bits, 00 read-only
csr_addr  input  12  CSR address
csr_wdata  input  XLEN  rs1/zimm operand
csr_rdata  output  XLEN  combinational old value of addressed CSR
trap_redirect  output  1  registered; fetch must load trap_target
trap_target  output  XLEN  registered redirect PC
pipe_flush  output  1  registered; kill IF/ID/EX contents

Behaviour:
- Reset values:
  - mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mtvec=MTVEC_RESET.
  - Sync flops=0; state=IDLE.
  - trap_redirect=0, pipe_flush=0, trap_target=0.
- ext_irq passes through a 2-flop synchroniser. mip.MEIP (bit 11) = synchroniser output. mip is read-only.
- Event qualification: events are considered only when state=IDLE and ex_valid=1.
- Priority, highest first:
  1. IRQ: MEIP & mie.MEIE (bit 11) & mstatus.MIE (bit 3).
  2. Exception: int_cause != 00.
  3. mret.
  4. CSR write.
- Trap entry, IRQ or exception, detected at edge N:
  - mepc<=ex_pc with bit 0 cleared.
  - mcause<=32'h8000_000B (IRQ), 2 (illegal), 11 (ecall) or 3 (ebreak).
  - MPIE<=MIE, MIE<=0.
  - trap_target<=mtvec; state<=FLUSH.
- mret at edge N: MIE<=MPIE, MPIE<=1, trap_target<=mepc, state<=FLUSH.
- FLUSH state lasts exactly one cycle (cycle N+1):
  - trap_redirect=1 and pipe_flush=1.
  - All events and CSR writes are ignored.
  - Returns to IDLE at the following edge.
- Latency: event visible at EX in cycle N gives redirect/flush in cycle N+1, one cycle wide.
- CSR access:
  - Write takes effect at the edge only if csr_we & ex_valid & state=IDLE & no higher-priority event.
  - New value = wdata (01), old|wdata (10) or old&~wdata (11); 00 performs no write.
  - csr_rdata always returns the pre-write value.
  - Writable fields only: mstatus bits 3 and 7; mie bit 11; mtvec [XLEN-1:2] (bits [1:0] read 0); mepc [XLEN-1:1]; mcause full width.
  - Unimplemented addresses read 0 and ignore writes.
- Addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344.
- Simultaneous events:
  - IRQ on an instruction with int_cause!=0: IRQ wins, mcause=0x8000000B, mepc=that PC.
  - IRQ on mret: IRQ wins.
  - Trap on a CSR instruction: the CSR write is dropped.
- A CSR write to mstatus.MIE=1 with MEIP already pending: the IRQ is taken on the next valid EX instruction, not the CSR instruction itself.
- ex_valid=0: no event, no write. A pending IRQ waits.
- Reset asserted mid-FLUSH: outputs drop to 0 asynchronously and no redirect is issued after release.

Test Plan:
- Reset, then read 0x305 with MTVEC_RESET=0x100 -> csr_rdata=0x100; all outputs 0.
- Write mtvec=0x203 (op 01), then ecall at ex_pc=0x40 -> next cycle trap_redirect=1, pipe_flush=1, trap_target=0x200; mepc=0x40, mcause=11, MIE=0; both pulses last exactly one cycle.
- Set MIE and MEIE, raise ext_irq with ex_valid=1 at pc=0x80 -> redirect occurs 3 cycles after irq rise (2 sync + 1); mcause=0x8000000B, mepc=0x80, MPIE=1.
- After that trap, mret -> trap_target=0x80, MIE=1, MPIE=1; with irq still high, the next valid instruction traps again.
- Illegal instruction (int_cause=01) with irq pending and enabled in the same cycle -> mcause=0x8000000B. Separately, csrrw on an instruction taking an IRQ -> target CSR unchanged.
- Deassert rstn during a FLUSH cycle -> trap_redirect/pipe_flush go 0 immediately, stay 0 after release, and all CSRs return to reset values.

Source files
------------

// File: rtl/trap_csr_unit_if.sv
// Bundle of EX-stage control, CSR access and fetch-redirect signals for the machine-mode trap unit.
// The slave side is the trap unit; the master side is the pipeline that drives it.
interface trap_csr_unit_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [1:0]      int_cause;
  logic            mret;
  logic            ext_irq;
  logic            csr_we;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            trap_redirect;
  logic [XLEN-1:0] trap_target;
  logic            pipe_flush;

  modport master (
    output ex_valid, ex_pc, int_cause, mret, ext_irq,
    output csr_we, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, trap_redirect, trap_target, pipe_flush
  );

  modport slave (
    input  ex_valid, ex_pc, int_cause, mret, ext_irq,
    input  csr_we, csr_op, csr_addr, csr_wdata,
    output csr_rdata, trap_redirect, trap_target, pipe_flush
  );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: holds mstatus/mie/mip/mtvec/mepc/mcause, arbitrates
// IRQ > exception > mret > CSR write, and issues a one-cycle registered flush/redirect.
module trap_csr_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = {XLEN{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rstn,
  trap_csr_unit_if.slave       bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [XLEN-1:0] CAUSE_IRQ    = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = {{(XLEN-4){1'b0}}, 4'h2};
  localparam logic [XLEN-1:0] CAUSE_ECALL  = {{(XLEN-4){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_EBREAK = {{(XLEN-4){1'b0}}, 4'h3};
  localparam logic [XLEN-1:0] MASK_MTVEC   = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MASK_MEPC    = {{(XLEN-1){1'b1}}, 1'b0};

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_meie_q, mie_meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            redirect_q, redirect_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            idle_valid_s;
  logic            irq_take_s;
  logic            exc_take_s;
  logic            mret_take_s;
  logic            csr_take_s;
  logic [XLEN-1:0] csr_old_s;
  logic [XLEN-1:0] csr_new_s;
  logic [XLEN-1:0] exc_cause_s;

  // Read mux: the pre-write value of the addressed CSR, zero for unimplemented addresses.
  always_comb begin
    csr_old_s = {XLEN{1'b0}};
    case (bus.csr_addr)
      ADDR_MSTATUS: begin
        csr_old_s[3] = mstatus_mie_q;
        csr_old_s[7] = mstatus_mpie_q;
      end
      ADDR_MIE:    csr_old_s[11] = mie_meie_q;
      ADDR_MTVEC:  csr_old_s     = mtvec_q;
      ADDR_MEPC:   csr_old_s     = mepc_q;
      ADDR_MCAUSE: csr_old_s     = mcause_q;
      ADDR_MIP:    csr_old_s[11] = sync_q[1];
      default:     csr_old_s     = {XLEN{1'b0}};
    endcase
  end

  assign bus.csr_rdata = csr_old_s;

  // Write-data combine for the write/set/clear CSR operations.
  always_comb begin
    case (bus.csr_op)
      2'b01:   csr_new_s = bus.csr_wdata;
      2'b10:   csr_new_s = csr_old_s | bus.csr_wdata;
      2'b11:   csr_new_s = csr_old_s & ~bus.csr_wdata;
      default: csr_new_s = csr_old_s;
    endcase
  end

  // Event arbitration; an IRQ needs the synchronised MEIP plus both enables.
  always_comb begin
    idle_valid_s = (state_q == IDLE) && bus.ex_valid;
    irq_take_s   = idle_valid_s && sync_q[1] && mie_meie_q && mstatus_mie_q;
    exc_take_s   = idle_valid_s && !irq_take_s && (bus.int_cause != 2'b00);
    mret_take_s  = idle_valid_s && !irq_take_s && !exc_take_s && bus.mret;
    csr_take_s   = idle_valid_s && !irq_take_s && !exc_take_s && !mret_take_s &&
                   bus.csr_we && (bus.csr_op != 2'b00);
    case (bus.int_cause)
      2'b01:   exc_cause_s = CAUSE_ILLEGAL;
      2'b10:   exc_cause_s = CAUSE_ECALL;
      2'b11:   exc_cause_s = CAUSE_EBREAK;
      default: exc_cause_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state for the FSM, the CSRs and the redirect outputs.
  always_comb begin
    state_d        = IDLE;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    target_d       = target_q;
    redirect_d     = 1'b0;
    flush_d        = 1'b0;

    if (irq_take_s || exc_take_s) begin
      mepc_d         = bus.ex_pc & MASK_MEPC;
      mcause_d       = irq_take_s ? CAUSE_IRQ : exc_cause_s;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      target_d       = mtvec_q;
      state_d        = FLUSH;
      redirect_d     = 1'b1;
      flush_d        = 1'b1;
    end else if (mret_take_s) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      target_d       = mepc_q;
      state_d        = FLUSH;
      redirect_d     = 1'b1;
      flush_d        = 1'b1;
    end else if (csr_take_s) begin
      case (bus.csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = csr_new_s[3];
          mstatus_mpie_d = csr_new_s[7];
        end
        ADDR_MIE:    mie_meie_d = csr_new_s[11];
        ADDR_MTVEC:  mtvec_d    = csr_new_s & MASK_MTVEC;
        ADDR_MEPC:   mepc_d     = csr_new_s & MASK_MEPC;
        ADDR_MCAUSE: mcause_d   = csr_new_s;
        default:     mcause_d   = mcause_q;
      endcase
    end else begin
      state_d = IDLE;
    end
  end

  // State, CSR, synchroniser and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      sync_q         <= 2'b00;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET & MASK_MTVEC;
      mepc_q         <= {XLEN{1'b0}};
      mcause_q       <= {XLEN{1'b0}};
      redirect_q     <= 1'b0;
      flush_q        <= 1'b0;
      target_q       <= {XLEN{1'b0}};
    end else begin
      state_q        <= state_d;
      sync_q         <= {sync_q[0], bus.ext_irq};
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      redirect_q     <= redirect_d;
      flush_q        <= flush_d;
      target_q       <= target_d;
    end
  end

  assign bus.trap_redirect = redirect_q;
  assign bus.pipe_flush    = flush_q;
  assign bus.trap_target   = target_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Bench for trap_csr_unit: directed vector table, hand-written IRQ/mret/reset sequences,
// then randomized traffic checked against a word-level model of the CSR file.
module tb_trap_csr_unit;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  trap_csr_unit_if #(.XLEN(32)) bus ();

  trap_csr_unit #(
    .XLEN        (32),
    .MTVEC_RESET (32'h0000_0100)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [1:0]  cause;
    logic        mr;
    logic        we;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_redir;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [1:0] cause,
                              input logic mr, input logic we, input logic [1:0] op,
                              input logic [11:0] addr, input logic [31:0] wd, input logic chk_rd,
                              input logic [31:0] exp_rd, input logic exp_redir,
                              input logic [31:0] exp_tgt);
    vec_t r;
    r.v = v; r.pc = pc; r.cause = cause; r.mr = mr; r.we = we; r.op = op;
    r.addr = addr; r.wd = wd; r.chk_rd = chk_rd; r.exp_rd = exp_rd;
    r.exp_redir = exp_redir; r.exp_tgt = exp_tgt;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    bus.ex_valid  = r.v;
    bus.ex_pc     = r.pc;
    bus.int_cause = r.cause;
    bus.mret      = r.mr;
    bus.csr_we    = r.we;
    bus.csr_op    = r.op;
    bus.csr_addr  = r.addr;
    bus.csr_wdata = r.wd;
  endtask

  // One instruction slot: drive at negedge, check read data, then check the registered outputs.
  task automatic cyc(input string nm, input vec_t r);
    @(negedge clk);
    drive(r);
    #1;
    if (r.chk_rd) chk({nm, ".rdata"}, bus.csr_rdata, r.exp_rd);
    @(posedge clk);
    #1;
    chk({nm, ".redirect"}, {31'd0, bus.trap_redirect}, {31'd0, r.exp_redir});
    chk({nm, ".flush"}, {31'd0, bus.pipe_flush}, {31'd0, r.exp_redir});
    if (r.exp_redir) chk({nm, ".target"}, bus.trap_target, r.exp_tgt);
  endtask

  function automatic vec_t rd(input logic [31:0] pc, input logic [11:0] addr, input logic [31:0] exp);
    return mk(1'b1, pc, 2'b00, 1'b0, 1'b0, 2'b00, addr, 32'd0, 1'b1, exp, 1'b0, 32'd0);
  endfunction

  function automatic vec_t wr(input logic [31:0] pc, input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp);
    return mk(1'b1, pc, 2'b00, 1'b0, 1'b1, op, addr, wd, 1'b1, exp, 1'b0, 32'd0);
  endfunction

  // Reference model: whole-word CSR values, masked to their writable fields.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_target;
  logic        m_flush;
  logic [1:0]  m_irq_hist;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_irq_hist[1] ? 32'h0000_0800 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_mstatus = 32'd0; m_mie = 32'd0; m_mtvec = 32'h0000_0100; m_mepc = 32'd0;
    m_mcause = 32'd0; m_target = 32'd0; m_flush = 1'b0; m_irq_hist = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive(mk(1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 2'b00, 12'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0));
    bus.ext_irq = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [11:0] addr_pool [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h340, 12'h7C0};

  initial begin
    vec_t r;
    logic [31:0] n_mstatus, n_mie, n_mtvec, n_mepc, n_mcause, n_target, old, nv;
    logic        n_flush, irq;

    bus.ext_irq = 1'b0;
    do_reset();
    @(posedge clk); #1;
    chk("reset.redirect", {31'd0, bus.trap_redirect}, 32'd0);
    chk("reset.flush", {31'd0, bus.pipe_flush}, 32'd0);
    chk("reset.target", bus.trap_target, 32'd0);

    tbl.push_back(rd(32'h10, 12'h305, 32'h0000_0100));
    tbl.push_back(wr(32'h10, 2'b01, 12'h305, 32'h0000_0203, 32'h0000_0100));
    tbl.push_back(rd(32'h10, 12'h305, 32'h0000_0200));
    tbl.push_back(wr(32'h10, 2'b10, 12'h304, 32'hFFFF_FFFF, 32'd0));
    tbl.push_back(rd(32'h10, 12'h304, 32'h0000_0800));
    tbl.push_back(wr(32'h10, 2'b11, 12'h304, 32'h0000_0800, 32'h0000_0800));
    tbl.push_back(rd(32'h10, 12'h304, 32'd0));
    tbl.push_back(wr(32'h10, 2'b01, 12'h342, 32'hDEAD_BEEF, 32'd0));
    tbl.push_back(rd(32'h10, 12'h342, 32'hDEAD_BEEF));
    tbl.push_back(wr(32'h10, 2'b01, 12'h341, 32'h1234_5677, 32'd0));
    tbl.push_back(rd(32'h10, 12'h341, 32'h1234_5676));
    tbl.push_back(wr(32'h10, 2'b01, 12'h300, 32'hFFFF_FFFF, 32'd0));
    tbl.push_back(rd(32'h10, 12'h300, 32'h0000_0088));
    tbl.push_back(wr(32'h10, 2'b11, 12'h300, 32'hFFFF_FFFF, 32'h0000_0088));
    tbl.push_back(rd(32'h10, 12'h300, 32'd0));
    tbl.push_back(wr(32'h10, 2'b01, 12'h340, 32'h0000_FFFF, 32'd0));
    tbl.push_back(rd(32'h10, 12'h340, 32'd0));
    tbl.push_back(wr(32'h10, 2'b00, 12'h342, 32'd0, 32'hDEAD_BEEF));
    tbl.push_back(rd(32'h10, 12'h342, 32'hDEAD_BEEF));
    tbl.push_back(mk(1'b0, 32'h10, 2'b00, 1'b0, 1'b1, 2'b01, 12'h342, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0));
    tbl.push_back(rd(32'h10, 12'h342, 32'hDEAD_BEEF));
    tbl.push_back(wr(32'h10, 2'b01, 12'h344, 32'hFFFF_FFFF, 32'd0));
    tbl.push_back(rd(32'h10, 12'h344, 32'd0));
    // ecall carrying a CSR write: trap wins, write dropped; writes during FLUSH ignored too
    tbl.push_back(mk(1'b1, 32'h40, 2'b10, 1'b0, 1'b1, 2'b01, 12'h342, 32'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0200));
    tbl.push_back(mk(1'b1, 32'h44, 2'b00, 1'b0, 1'b1, 2'b01, 12'h342, 32'd7, 1'b1, 32'd11, 1'b0, 32'd0));
    tbl.push_back(rd(32'h44, 12'h342, 32'd11));
    tbl.push_back(rd(32'h44, 12'h341, 32'h0000_0040));
    tbl.push_back(rd(32'h44, 12'h300, 32'd0));
    tbl.push_back(mk(1'b1, 32'h44, 2'b11, 1'b0, 1'b0, 2'b00, 12'h342, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0200));
    tbl.push_back(rd(32'h200, 12'h342, 32'd3));
    tbl.push_back(mk(1'b1, 32'h204, 2'b00, 1'b1, 1'b0, 2'b00, 12'h300, 32'd0, 1'b1, 32'd0, 1'b1, 32'h0000_0044));
    tbl.push_back(rd(32'h44, 12'h300, 32'h0000_0080));
    tbl.push_back(mk(1'b1, 32'h48, 2'b01, 1'b0, 1'b0, 2'b00, 12'h300, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0200));
    tbl.push_back(mk(1'b1, 32'h200, 2'b10, 1'b1, 1'b0, 2'b00, 12'h342, 32'd0, 1'b1, 32'd2, 1'b0, 32'd0));
    tbl.push_back(rd(32'h204, 12'h300, 32'd0));
    tbl.push_back(mk(1'b0, 32'h208, 2'b00, 1'b1, 1'b0, 2'b00, 12'h300, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0));

    foreach (tbl[i]) cyc($sformatf("tbl%0d", i), tbl[i]);

    // IRQ latency: two synchroniser edges plus the trap edge
    cyc("irq.mstatus", wr(32'h7C, 2'b10, 12'h300, 32'h8, 32'd0));
    cyc("irq.mie", wr(32'h7C, 2'b10, 12'h304, 32'h800, 32'd0));
    bus.ext_irq = 1'b1;
    cyc("irq.e1", rd(32'h80, 12'h344, 32'd0));
    cyc("irq.e2", rd(32'h80, 12'h344, 32'd0));
    r = rd(32'h80, 12'h344, 32'h800); r.exp_redir = 1'b1; r.exp_tgt = 32'h200;
    cyc("irq.e3", r);
    cyc("irq.cause", rd(32'h200, 12'h342, 32'h8000_000B));
    cyc("irq.mepc", rd(32'h200, 12'h341, 32'h80));
    cyc("irq.mstatus_rd", rd(32'h200, 12'h300, 32'h80));
    r = mk(1'b1, 32'h204, 2'b00, 1'b1, 1'b0, 2'b00, 12'h300, 32'd0, 1'b1, 32'h80, 1'b1, 32'h80);
    cyc("mret", r);
    cyc("mret.mstatus", rd(32'h80, 12'h300, 32'h88));
    r = rd(32'h84, 12'h300, 32'h88); r.exp_redir = 1'b1; r.exp_tgt = 32'h200;
    cyc("retrap", r);
    cyc("retrap.mepc", rd(32'h200, 12'h341, 32'h84));
    // MIE set by a CSR instruction: the IRQ lands on the following instruction
    cyc("csr_mie.noirq", wr(32'h88, 2'b10, 12'h300, 32'h8, 32'h80));
    r = mk(1'b1, 32'h91, 2'b01, 1'b0, 1'b0, 2'b00, 12'h300, 32'd0, 1'b0, 32'd0, 1'b1, 32'h200);
    cyc("ill_irq", r);
    cyc("ill_irq.cause", rd(32'h200, 12'h342, 32'h8000_000B));
    cyc("ill_irq.mepc", rd(32'h200, 12'h341, 32'h90));
    cyc("csrrw.set", wr(32'h204, 2'b10, 12'h300, 32'h8, 32'h80));
    r = wr(32'h94, 2'b01, 12'h305, 32'h400, 32'h200); r.exp_redir = 1'b1; r.exp_tgt = 32'h200;
    cyc("csrrw_irq", r);
    cyc("csrrw_irq.mtvec", rd(32'h200, 12'h305, 32'h200));
    cyc("mret_irq.set", wr(32'h204, 2'b10, 12'h300, 32'h8, 32'h80));
    r = mk(1'b1, 32'h98, 2'b00, 1'b1, 1'b0, 2'b00, 12'h300, 32'd0, 1'b0, 32'd0, 1'b1, 32'h200);
    cyc("mret_irq", r);
    cyc("mret_irq.mepc", rd(32'h200, 12'h341, 32'h98));
    cyc("rstflush.set", wr(32'h204, 2'b10, 12'h300, 32'h8, 32'h80));
    r = rd(32'h9C, 12'h300, 32'h88); r.exp_redir = 1'b1; r.exp_tgt = 32'h200;
    cyc("rstflush.trap", r);
    rstn = 1'b0;
    bus.ext_irq = 1'b0;
    #1;
    chk("rstflush.redirect", {31'd0, bus.trap_redirect}, 32'd0);
    chk("rstflush.flush", {31'd0, bus.pipe_flush}, 32'd0);
    chk("rstflush.target", bus.trap_target, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    cyc("post.mtvec", rd(32'h10, 12'h305, 32'h100));
    cyc("post.mstatus", rd(32'h10, 12'h300, 32'd0));
    cyc("post.mie", rd(32'h10, 12'h304, 32'd0));
    cyc("post.mepc", rd(32'h10, 12'h341, 32'd0));
    cyc("post.mcause", rd(32'h10, 12'h342, 32'd0));
    cyc("post.mip", rd(32'h10, 12'h344, 32'd0));

    // Randomized traffic against the reference model
    do_reset();
    m_reset();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      r.v = ($urandom_range(0, 3) != 0);
      r.pc = $urandom;
      r.cause = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r.mr = ($urandom_range(0, 9) == 0);
      r.we = $urandom_range(0, 1) == 1;
      r.op = 2'($urandom_range(0, 3));
      r.addr = addr_pool[$urandom_range(0, 7)];
      r.wd = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      drive(r);
      if ($urandom_range(0, 9) == 0) bus.ext_irq = ~bus.ext_irq;
      #1;
      chk($sformatf("rnd%0d.rdata", k), bus.csr_rdata, m_read(r.addr));

      n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mepc = m_mepc;
      n_mcause = m_mcause; n_target = m_target; n_flush = 1'b0;
      irq = m_irq_hist[1] && m_mie[11] && m_mstatus[3];
      if (!m_flush && r.v) begin
        if (irq || r.cause != 2'b00) begin
          n_mepc = r.pc & 32'hFFFF_FFFE;
          n_mcause = irq ? 32'h8000_000B : (r.cause == 2'b01 ? 32'd2 : (r.cause == 2'b10 ? 32'd11 : 32'd3));
          n_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
          n_target = m_mtvec;
          n_flush = 1'b1;
        end else if (r.mr) begin
          n_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
          n_target = m_mepc;
          n_flush = 1'b1;
        end else if (r.we && r.op != 2'b00) begin
          old = m_read(r.addr);
          nv = (r.op == 2'b01) ? r.wd : ((r.op == 2'b10) ? (old | r.wd) : (old & ~r.wd));
          case (r.addr)
            12'h300: n_mstatus = nv & 32'h88;
            12'h304: n_mie = nv & 32'h800;
            12'h305: n_mtvec = nv & 32'hFFFF_FFFC;
            12'h341: n_mepc = nv & 32'hFFFF_FFFE;
            12'h342: n_mcause = nv;
            default: ;
          endcase
        end
      end

      @(posedge clk);
      m_irq_hist = {m_irq_hist[0], bus.ext_irq};
      m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mepc = n_mepc;
      m_mcause = n_mcause; m_target = n_target; m_flush = n_flush;
      #1;
      chk($sformatf("rnd%0d.redirect", k), {31'd0, bus.trap_redirect}, {31'd0, m_flush});
      chk($sformatf("rnd%0d.flush", k), {31'd0, bus.pipe_flush}, {31'd0, m_flush});
      if (m_flush) chk($sformatf("rnd%0d.target", k), bus.trap_target, m_target);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
